// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared bank state type and default dimensions for the JPEG transpose buffer
package jpeg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } tbuf_state_t;

    localparam int JPEG_TBUF_N_DEF = 8;
    localparam int JPEG_TBUF_W_DEF = 12;

    // A bank accepts rows until its last row lands.
    function automatic logic bank_writable(tbuf_state_t s);
        return (s == EMPTY) || (s == FILL);
    endfunction

    // A bank presents columns from the moment it is complete until its last column leaves.
    function automatic logic bank_readable(tbuf_state_t s);
        return (s == FULL) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/jpeg_tbuf_bank.sv
// rtl/jpeg_tbuf_bank.sv - one N x N element register bank with row write and column/row read
module jpeg_tbuf_bank #(
    parameter int N = 8,
    parameter int W = 12,
    localparam int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_row,
    input  logic [N*W-1:0]  wr_data,
    input  logic [AW-1:0]   rd_idx,
    input  logic            transpose,
    output logic [N*W-1:0]  rd_data
);

    // Storage is deliberately left uninitialised; bank state in the parent says what is valid.
    logic [N*W-1:0] rows [N];

    // Whole-row write: one input vector becomes one stored row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_row] <= wr_data;
        end
    end

    // Read either column rd_idx (element r taken from row r) or row rd_idx unchanged.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) begin
            if (transpose) begin
                rd_data[r*W +: W] = rows[r][int'(rd_idx)*W +: W];
            end else begin
                rd_data[r*W +: W] = rows[rd_idx][r*W +: W];
            end
        end
    end

endmodule

// File: rtl/jpeg_tbuf.sv
// rtl/jpeg_tbuf.sv - ping-pong row-in/column-out transpose buffer; optional JPEG_TBUF_PASS_EN adds transpose_i
module jpeg_tbuf
    import jpeg_pkg::*;
#(
    parameter int N = JPEG_TBUF_N_DEF,
    parameter int W = JPEG_TBUF_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [N*W-1:0]  in_row_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [N*W-1:0]  out_col_o,
    output logic            out_last_o,
    output logic            busy_o
`ifdef JPEG_TBUF_PASS_EN
    ,
    input  logic            transpose_i
`endif
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

    tbuf_state_t    state     [2];
    tbuf_state_t    state_nxt [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [AW-1:0]  wr_row;
    logic [AW-1:0]  rd_col;
    logic           in_hs;
    logic           out_hs;
    logic           row_last;
    logic           col_last;
    logic [1:0]     mode;
    logic [N*W-1:0] bank_data [2];

    // Handshake qualifiers; reset forces both ready/valid low so nothing completes under reset.
    always_comb begin
        in_ready_o  = !rst_i && bank_writable(state[wr_ptr]);
        out_valid_o = !rst_i && bank_readable(state[rd_ptr]);
        in_hs       = in_valid_i && in_ready_o;
        out_hs      = out_valid_o && out_ready_i;
        row_last    = (wr_row == IDX_LAST);
        col_last    = (rd_col == IDX_LAST);
        out_last_o  = out_valid_o && col_last;
        busy_o      = !rst_i && ((state[0] != EMPTY) || (state[1] != EMPTY));
        out_col_o   = bank_data[rd_ptr];
    end

    // Bank next-state: the write side and read side never address the same bank in one cycle,
    // because one needs EMPTY/FILL and the other FULL/DRAIN.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_nxt[b] = state[b];
            if (in_hs && (int'(wr_ptr) == b)) begin
                state_nxt[b] = row_last ? FULL : FILL;
            end
            if (out_hs && (int'(rd_ptr) == b)) begin
                state_nxt[b] = col_last ? EMPTY : DRAIN;
            end
        end
    end

    // Bank state register; flush behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 2; b++) begin
            if (rst_i || flush_i) begin
                state[b] <= EMPTY;
            end else begin
                state[b] <= state_nxt[b];
            end
        end
    end

    // Write row counter and write-bank pointer; the pointer flips as a block completes.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_row <= '0;
            wr_ptr <= 1'b0;
        end else if (in_hs) begin
            if (row_last) begin
                wr_row <= '0;
                wr_ptr <= ~wr_ptr;
            end else begin
                wr_row <= wr_row + 1'b1;
            end
        end
    end

    // Read column counter and read-bank pointer; the pointer flips after the last column.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_col <= '0;
            rd_ptr <= 1'b0;
        end else if (out_hs) begin
            if (col_last) begin
                rd_col <= '0;
                rd_ptr <= ~rd_ptr;
            end else begin
                rd_col <= rd_col + 1'b1;
            end
        end
    end

`ifdef JPEG_TBUF_PASS_EN
    // Per-bank read mode, captured with the first row of each block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode <= 2'b11;
        end else if (in_hs && (wr_row == '0)) begin
            mode[wr_ptr] <= transpose_i;
        end
    end
`else
    assign mode = 2'b11;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        jpeg_tbuf_bank #(
            .N(N),
            .W(W)
        ) u_bank (
            .clk       (clk_i),
            .wr_en     (in_hs && !flush_i && (int'(wr_ptr) == b)),
            .wr_row    (wr_row),
            .wr_data   (in_row_i),
            .rd_idx    (rd_col),
            .transpose (mode[b]),
            .rd_data   (bank_data[b])
        );
    end

endmodule

// File: doc/jpeg_tbuf.md
JPEG_TBUF -- requirements
Module: jpeg_tbuf

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the block dimension (rows per block, elements per row); legal values are 4, 8 and 16.
REQ-002 The block SHALL have parameter W, default 12, giving the element width in bits.
REQ-003 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 flush_i  in  1  synchronous discard of all buffered data.
REQ-006 in_valid_i  in  1  a row is presented on in_row_i.
REQ-007 in_ready_o  out  1  a row can be accepted this cycle.
REQ-008 in_row_i  in  N*W  input row; element c occupies bits [c*W +: W].
REQ-009 out_valid_o  out  1  a column is presented on out_col_o.
REQ-010 out_ready_i  in  1  the consumer accepts the column this cycle.
REQ-011 out_col_o  out  N*W  output vector; element r occupies bits [r*W +: W].
REQ-012 out_last_o  out  1  high with the final (N-1) output vector of a block.
REQ-013 busy_o  out  1  high when any bank is not EMPTY.

Function
REQ-014 The buffer SHALL hold two N x N banks used ping-pong. Each bank SHALL have state EMPTY, FILL, FULL or DRAIN.
REQ-015 A handshake SHALL occur on a side when valid and ready are both high on the same rising edge.
REQ-016 in_ready_o SHALL be high when the write bank is EMPTY or FILL and rst_i is low.
REQ-017 On each input handshake, the block SHALL store in_row_i as row wr_row of the write bank and increment wr_row; the first handshake SHALL move the bank from EMPTY to FILL.
REQ-018 On the handshake with wr_row = N-1, the bank SHALL become FULL, wr_row SHALL wrap to 0, and the write-bank pointer SHALL toggle.
REQ-019 out_valid_o SHALL be high when the read bank is FULL or DRAIN. out_col_o element r SHALL equal element rd_col of row r in that bank (transpose).
REQ-020 The first output vector SHALL be valid on the cycle after the last row of the block is accepted (latency 1 cycle).
REQ-021 On each output handshake, rd_col SHALL increment and a FULL bank SHALL move to DRAIN. On the handshake with rd_col = N-1 (out_last_o high), the bank SHALL become EMPTY, rd_col SHALL wrap to 0, and the read-bank pointer SHALL toggle.
REQ-022 A bank freed by its last output handshake SHALL be writable on the next cycle.
REQ-023 With in_valid_i and out_ready_i held high, sustained throughput SHALL be one row in and one column out per cycle, with no bubbles.
REQ-024 An input and an output handshake in the same cycle (always on different banks) SHALL both complete.
REQ-025 While out_valid_o is high and out_ready_i is low, out_col_o and out_last_o SHALL hold stable.
REQ-026 When both banks are FULL or DRAIN, in_ready_o SHALL be low, and no row SHALL be lost or overwritten.
REQ-027 flush_i SHALL act like reset on the next edge: banks EMPTY, all pointers and counters 0. Any handshake in that same cycle SHALL be discarded. rst_i SHALL have priority over flush_i.

Reset
REQ-028 While rst_i is high, in_ready_o, out_valid_o, out_last_o and busy_o SHALL be 0.
REQ-029 After reset: both banks EMPTY, wr_row = rd_col = 0, both bank pointers 0, and in_ready_o = 1 on the first cycle with rst_i low.
REQ-030 Reset asserted mid-block SHALL discard all partial and full data; bank contents need not be cleared.
REQ-031 out_col_o content is don't-care while out_valid_o is low.

Configuration
REQ-032 With macro JPEG_TBUF_PASS_EN defined, the block SHALL add input transpose_i (1 bit), sampled at the first row handshake of each block and stored per bank. A stored value of 0 SHALL output rows unchanged (out_col_o = row rd_col); 1 SHALL transpose.
REQ-033 Without JPEG_TBUF_PASS_EN, the transpose_i port SHALL be absent and the block SHALL always transpose.

Structure
REQ-034 Package jpeg_pkg SHALL hold tbuf_state_t (EMPTY, FILL, FULL, DRAIN) and the constants JPEG_TBUF_N_DEF = 8 and JPEG_TBUF_W_DEF = 12.
REQ-035 One sub-module, jpeg_tbuf_bank, SHALL implement a single N x N register bank with row write and column/row read; jpeg_tbuf SHALL instantiate it twice.

Verification
REQ-036 Single block, N=8, W=12: rows r=0..7 with element c = 8r+c. Required: 8 columns; column 0 = {56,48,40,32,24,16,8,0} with element 0 LSB; out_last_o high only on column 7; first out_valid_o one cycle after row 7.
REQ-037 Three back-to-back blocks with out_ready_i=1: in_ready_o stays 1 for all 24 input cycles and 24 contiguous valid output cycles.
REQ-038 out_ready_i=0 with 17 rows offered: in_ready_o drops after row 16 and busy_o=1. Raising out_ready_i produces columns of block 0 then block 1, and row 17 is accepted the cycle after block 0's column 7.
REQ-039 out_ready_i toggling every cycle: each column holds stable while stalled, and no duplicates or drops occur.
REQ-040 flush_i after row 5, then rst_i after row 3 of a new block: no output results; busy_o=0 next cycle; the following clean block outputs correctly.
REQ-041 JPEG_TBUF_PASS_EN defined, transpose_i=0 for the REQ-036 data: output vector 0 = {7,6,5,4,3,2,1,0}; the next block with transpose_i=1 transposes.
